// File: rtl/rv32i_fetch_queue.sv
// RV32I instruction fetch queue: credit-gated sequential fetch, in-order response
// PC tracking, response dropping after redirects, and a small instruction FIFO.
module rv32i_fetch_queue #(
    parameter int          C_DEPTH        = 4,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        ireqvalid_o,
    input  logic        ireqready_i,
    output logic [31:0] ireqaddr_o,
    input  logic        irspvalid_i,
    input  logic        irsperr_i,
    input  logic [31:0] irspdata_i,
    output logic        ins_vld_o,
    input  logic        ins_rd_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_acc_fault_o
);

    localparam int C_AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int C_CW = C_AW + 1;

    typedef logic [C_CW-1:0] cnt_t;
    typedef logic [C_AW-1:0] ptr_t;

    // Handshakes: a request transfers when ireqvalid_o & ireqready_i; responses
    // have no back-pressure; a pop happens when ins_rd_i & ins_vld_o.
    logic [31:0] r_pc;
    cnt_t        r_occ;
    cnt_t        r_out;
    cnt_t        r_drop;

    logic [31:0] r_q_data [C_DEPTH];
    logic [31:0] r_q_pc   [C_DEPTH];
    logic        r_q_err  [C_DEPTH];
    ptr_t        r_q_wr;
    ptr_t        r_q_rd;

    logic [31:0] r_t_pc   [C_DEPTH];
    ptr_t        r_t_wr;
    ptr_t        r_t_rd;

    logic        w_credit;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_rsp_drop;
    logic        w_push;
    logic        w_pop;
    cnt_t        w_occ_nxt;
    cnt_t        w_out_nxt;
    cnt_t        w_drop_nxt;
    logic        w_unused_bits;

    assign w_unused_bits = ^jump_addr_i[1:0];

    // Credits are counted before this cycle's pop so the queue can never overflow.
    assign w_credit    = ({1'b0, r_occ} + {1'b0, r_out}) < (C_CW + 1)'(C_DEPTH);
    assign w_req_valid = resetb_i & ~jump_i & w_credit;
    assign w_req_fire  = w_req_valid & ireqready_i;
    assign w_rsp_drop  = irspvalid_i & (jump_i | (r_drop != '0));
    assign w_push      = irspvalid_i & ~w_rsp_drop;
    assign w_pop       = ins_rd_i & (r_occ != '0) & ~jump_i;

    always_comb begin
        w_out_nxt  = r_out + cnt_t'(w_req_fire) - cnt_t'(irspvalid_i);
        w_drop_nxt = r_drop;
        w_occ_nxt  = r_occ + cnt_t'(w_push) - cnt_t'(w_pop);
        if (jump_i) begin
            // Everything still in flight after a redirect belongs to the old stream.
            w_drop_nxt = w_out_nxt;
            w_occ_nxt  = '0;
        end else if (irspvalid_i && (r_drop != '0)) begin
            w_drop_nxt = r_drop - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_pc   <= C_RESET_VECTOR;
            r_occ  <= '0;
            r_out  <= '0;
            r_drop <= '0;
            r_q_wr <= '0;
            r_q_rd <= '0;
            r_t_wr <= '0;
            r_t_rd <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_out  <= w_out_nxt;
            r_drop <= w_drop_nxt;
            if (jump_i) begin
                r_pc <= {jump_addr_i[31:2], 2'b00};
            end else if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_req_fire) begin
                r_t_wr <= r_t_wr + ptr_t'(1);
            end
            if (irspvalid_i) begin
                r_t_rd <= r_t_rd + ptr_t'(1);
            end
            if (jump_i) begin
                r_q_wr <= '0;
                r_q_rd <= '0;
            end else begin
                if (w_push) begin
                    r_q_wr <= r_q_wr + ptr_t'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + ptr_t'(1);
                end
            end
        end
    end

    // Storage needs no reset: validity is carried entirely by the counters.
    always_ff @(posedge clk_i) begin
        if (w_req_fire) begin
            r_t_pc[r_t_wr] <= r_pc;
        end
        if (w_push) begin
            r_q_data[r_q_wr] <= irspdata_i;
            r_q_pc[r_q_wr]   <= r_t_pc[r_t_rd];
            r_q_err[r_q_wr]  <= irsperr_i;
        end
    end

    assign ireqvalid_o     = w_req_valid;
    assign ireqaddr_o      = r_pc;
    assign ins_vld_o       = (r_occ != '0);
    assign ins_o           = r_q_data[r_q_rd];
    assign ins_pc_o        = r_q_pc[r_q_rd];
    assign ins_acc_fault_o = r_q_err[r_q_rd];

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Directed bench for rv32i_fetch_queue: a cycle table for streaming fetch plus
// hand-written sequences for stall, redirect, access fault and address wrap.
module tb_rv32i_fetch_queue;

    logic        clk = 1'b0;
    logic        resetb;
    logic        jump;
    logic [31:0] jump_addr;
    logic        ireqready;
    logic        irspvalid;
    logic        irsperr;
    logic [31:0] irspdata;
    logic        ins_rd;

    logic        ireqvalid,  w_ireqvalid;
    logic [31:0] ireqaddr,   w_ireqaddr;
    logic        ins_vld,    w_ins_vld;
    logic [31:0] ins,        w_ins;
    logic [31:0] ins_pc,     w_ins_pc;
    logic        ins_fault,  w_ins_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_fetch_queue #(.C_DEPTH(4), .C_RESET_VECTOR(32'h0000_0000)) u_dut (
        .clk_i(clk), .resetb_i(resetb), .jump_i(jump), .jump_addr_i(jump_addr),
        .ireqvalid_o(ireqvalid), .ireqready_i(ireqready), .ireqaddr_o(ireqaddr),
        .irspvalid_i(irspvalid), .irsperr_i(irsperr), .irspdata_i(irspdata),
        .ins_vld_o(ins_vld), .ins_rd_i(ins_rd), .ins_o(ins), .ins_pc_o(ins_pc),
        .ins_acc_fault_o(ins_fault)
    );

    // Second instance whose fetch stream crosses the top of the address space.
    rv32i_fetch_queue #(.C_DEPTH(4), .C_RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i(clk), .resetb_i(resetb), .jump_i(jump), .jump_addr_i(jump_addr),
        .ireqvalid_o(w_ireqvalid), .ireqready_i(ireqready), .ireqaddr_o(w_ireqaddr),
        .irspvalid_i(irspvalid), .irsperr_i(irsperr), .irspdata_i(irspdata),
        .ins_vld_o(w_ins_vld), .ins_rd_i(ins_rd), .ins_o(w_ins), .ins_pc_o(w_ins_pc),
        .ins_acc_fault_o(w_ins_fault)
    );

    typedef struct {
        logic        rdy;
        logic        rspv;
        logic [31:0] rsp_addr;
        logic        rd;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    // Instruction word the bus model returns for a given fetch address.
    function automatic logic [31:0] dfn(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: inputs change on the falling edge, outputs are sampled 1 unit later.
    task automatic cyc(input logic rdy, input logic rv, input logic rerr, input logic [31:0] rdata,
                       input logic rd, input logic jmp, input logic [31:0] jaddr);
        @(negedge clk);
        ireqready = rdy;
        irspvalid = rv;
        irsperr   = rerr;
        irspdata  = rdata;
        ins_rd    = rd;
        jump      = jmp;
        jump_addr = jaddr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb    = 1'b0;
        ireqready = 1'b0;
        irspvalid = 1'b0;
        irsperr   = 1'b0;
        irspdata  = '0;
        ins_rd    = 1'b0;
        jump      = 1'b0;
        jump_addr = '0;
        #1;
        ck("rst_reqvalid", 32'(ireqvalid), 32'd0);
        ck("rst_ins_vld", 32'(ins_vld), 32'd0);
        ck("rst_wrap_reqvalid", 32'(w_ireqvalid), 32'd0);
        ck("rst_wrap_ins_vld", 32'(w_ins_vld), 32'd0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        resetb = 1'b1;
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h08, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        // Streaming fetch with one-cycle response latency, then pop every cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rdy, vecs[i].rspv, 1'b0, dfn(vecs[i].rsp_addr), vecs[i].rd, 1'b0, 32'h0);
            ck($sformatf("tab%0d_reqvalid", i), 32'(ireqvalid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) ck($sformatf("tab%0d_reqaddr", i), ireqaddr, vecs[i].exp_addr);
            ck($sformatf("tab%0d_ins_vld", i), 32'(ins_vld), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                ck($sformatf("tab%0d_ins_pc", i), ins_pc, vecs[i].exp_pc);
                ck($sformatf("tab%0d_ins", i), ins, dfn(vecs[i].exp_pc));
                ck($sformatf("tab%0d_fault", i), 32'(ins_fault), 32'd0);
            end
        end

        // Bus stalled after reset: address holds, empty-queue pop ignored.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, (k == 2), 1'b0, 32'h0);
            ck("stall_reqvalid", 32'(ireqvalid), 32'd1);
            ck("stall_reqaddr", ireqaddr, 32'h0000_0000);
            ck("stall_wrap_reqaddr", w_ireqaddr, 32'hFFFF_FFF8);
            ck("stall_ins_vld", 32'(ins_vld), 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("stall_first_addr", ireqaddr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, dfn(32'h0), 1'b0, 1'b0, 32'h0);
        ck("stall_rsp_cycle_vld", 32'(ins_vld), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("stall_head_vld", 32'(ins_vld), 32'd1);
        ck("stall_head_pc", ins_pc, 32'h0);

        // Redirect with two requests outstanding: both late responses discarded.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("jmp_addr0", ireqaddr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("jmp_addr1", ireqaddr, 32'h4);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'h0), 1'b0, 1'b1, 32'h0000_1003);
        ck("jmp_reqvalid_in_jump", 32'(ireqvalid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'h4), 1'b0, 1'b0, 32'h0);
        ck("jmp_target_valid", 32'(ireqvalid), 32'd1);
        ck("jmp_target_addr", ireqaddr, 32'h0000_1000);
        ck("jmp_drop_vld", 32'(ins_vld), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, dfn(32'h1000), 1'b0, 1'b0, 32'h0);
        ck("jmp_rsp_cycle_vld", 32'(ins_vld), 32'd0);
        ck("jmp_next_addr", ireqaddr, 32'h0000_1004);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("jmp_head_vld", 32'(ins_vld), 32'd1);
        ck("jmp_head_pc", ins_pc, 32'h0000_1000);
        ck("jmp_head_ins", ins, dfn(32'h1000));
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("jmp_single_entry", 32'(ins_vld), 32'd0);

        // Access fault on 0x8 is queued and flagged; neighbours are clean.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'h0), 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'h4), 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, dfn(32'h8), 1'b0, 1'b0, 32'h0);
        ck("flt_addr3", ireqaddr, 32'hC);
        cyc(1'b0, 1'b1, 1'b0, dfn(32'hC), 1'b0, 1'b0, 32'h0);
        ck("flt_credit_stop", 32'(ireqvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] epc;
            epc = 32'(k) * 32'd4;
            cyc(1'b0, 1'b0, 1'b0, 32'h0, (k < 3), 1'b0, 32'h0);
            ck($sformatf("flt_pc%0d", k), ins_pc, epc);
            ck($sformatf("flt_ins%0d", k), ins, dfn(epc));
            ck($sformatf("flt_fault%0d", k), 32'(ins_fault), 32'(epc == 32'h8));
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000);
        ck("flt_jump_reqvalid", 32'(ireqvalid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("flt_flush_vld", 32'(ins_vld), 32'd0);
        ck("flt_flush_addr", ireqaddr, 32'h0000_2000);

        // Reset vector near the top of memory wraps to zero.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        ck("wrap_addr0", w_ireqaddr, 32'hFFFF_FFF8);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'hFFFF_FFF8), 1'b0, 1'b0, 32'h0);
        ck("wrap_addr1", w_ireqaddr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, dfn(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
        ck("wrap_addr2", w_ireqaddr, 32'h0000_0000);
        ck("wrap_head_vld", 32'(w_ins_vld), 32'd1);
        ck("wrap_head_pc", w_ins_pc, 32'hFFFF_FFF8);
        ck("wrap_head_ins", w_ins, dfn(32'hFFFF_FFF8));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
